// File: rtl/counter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_pkg : shared states, display constants and anode helper. Rev 1.0
// ----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    // A digit is blanked when it and every more-significant nibble are zero;
    // digit 0 always stays lit so a zero value still shows "0".
    function automatic logic [3:0] anode_pattern(input logic [1:0]  idx,
                                                 input logic [15:0] value,
                                                 input logic        blank_en);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && value[4*i +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        if (blank_en && idx != 2'd0 && upper_zero)
            return AN_OFF;
        return ~(4'b0001 << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_run_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_run_ctrl_if : buttons, counter value and display bus. Rev 1.0
// ----------------------------------------------------------------------------
interface counter_run_ctrl_if;

    logic        btn_start_stop;
    logic        btn_clear;
    logic [15:0] count_in;
    logic        count_en;
    logic        count_clr;
    logic        running;
    logic [3:0]  digit_val;
    logic [3:0]  an_n;

    modport master (
        output btn_start_stop, btn_clear, count_in,
        input  count_en, count_clr, running, digit_val, an_n
    );

    modport slave (
        input  btn_start_stop, btn_clear, count_in,
        output count_en, count_clr, running, digit_val, an_n
    );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_debounce : 2-flop sync, stable-count debounce, rising-edge press. Rev 1.0
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic raw,
    output logic      level,
    output logic      press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
                level_d = ~level_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/counter_run_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_run_ctrl : run/pause FSM for the up-counter plus 4-digit scan. Rev 1.0
// ----------------------------------------------------------------------------
module counter_run_ctrl
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 1000,
    parameter int SCAN_DIV        = 1024,
    parameter int LZ_BLANK        = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    counter_run_ctrl_if.slave  bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    logic ss_press, clr_press;
    logic ss_level_unused, clr_level_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_start_stop),
        .level (ss_level_unused),
        .press (ss_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_clear),
        .level (clr_level_unused),
        .press (clr_press)
    );

    state_t        state_q, state_d;
    logic [TW-1:0] presc_q, presc_d;
    logic          count_en_q, count_en_d;
    logic          count_clr_q, count_clr_d;
    logic          running_q;

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        count_en_d  = 1'b0;
        count_clr_d = 1'b0;

        // Clear has priority and swallows a coincident start/stop press.
        if (clr_press) begin
            state_d     = ST_IDLE;
            count_clr_d = 1'b1;
        end else if (ss_press) begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end

        if (state_d == ST_RUN) begin
            if (state_q != ST_RUN) begin
                presc_d = '0;
            end else if (presc_q == TW'(TICK_DIV - 1)) begin
                presc_d    = '0;
                count_en_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            running_q   <= (state_d == ST_RUN);
        end
    end

    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [3:0]    digit_val_q, digit_val_d;
    logic [3:0]    an_n_q, an_n_d;

    // Outputs are built from the next digit index so they line up with it.
    always_comb begin
        scan_d      = scan_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d      = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end
        digit_val_d = bus.count_in[{digit_idx_d, 2'b00} +: 4];
        an_n_d      = anode_pattern(digit_idx_d, bus.count_in, LZ_BLANK != 0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q      <= '0;
            digit_idx_q <= 2'd0;
            digit_val_q <= 4'h0;
            an_n_q      <= 4'b1110;
        end else begin
            scan_q      <= scan_d;
            digit_idx_q <= digit_idx_d;
            digit_val_q <= digit_val_d;
            an_n_q      <= an_n_d;
        end
    end

    assign bus.count_en  = count_en_q;
    assign bus.count_clr = count_clr_q;
    assign bus.running   = running_q;
    assign bus.digit_val = digit_val_q;
    assign bus.an_n      = an_n_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_run_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_counter_run_ctrl : directed scoreboard bench for counter_run_ctrl. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_run_ctrl;

    localparam int DBC  = 4;
    localparam int TDIV = 5;
    localparam int SDIV = 4;

    localparam int K_EN    = 0;
    localparam int K_CLR   = 1;
    localparam int K_PRESS = 2;
    localparam int K_RISE  = 3;
    localparam int K_FALL  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_run_ctrl_if bus();

    counter_run_ctrl #(
        .DEBOUNCE_CYCLES (DBC),
        .TICK_DIV        (TDIV),
        .SCAN_DIV        (SDIV),
        .LZ_BLANK        (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_scan   = 0;
    int m_idx    = 0;
    logic run_prev = 1'b0;

    int obs_q[5][$];
    int exp_q[5][$];

    // Reference digit scanner, used only to know which digit should be lit.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_scan <= 0;
            m_idx  <= 0;
        end else if (m_scan == SDIV - 1) begin
            m_scan <= 0;
            m_idx  <= (m_idx + 1) % 4;
        end else begin
            m_scan <= m_scan + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.count_en)                 obs_q[K_EN].push_back(cyc);
            if (bus.count_clr)                obs_q[K_CLR].push_back(cyc);
            if (dut.u_db_ss.press)            obs_q[K_PRESS].push_back(cyc);
            if (bus.running && !run_prev)     obs_q[K_RISE].push_back(cyc);
            if (!bus.running && run_prev)     obs_q[K_FALL].push_back(cyc);
        end
        run_prev = bus.running;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic go_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_events(input string tag, input int k);
        int n;
        int o;
        int e;
        chk($sformatf("%s_count", tag), obs_q[k].size(), exp_q[k].size());
        n = (obs_q[k].size() > exp_q[k].size()) ? obs_q[k].size() : exp_q[k].size();
        for (int i = 0; i < n; i++) begin
            o = (i < obs_q[k].size()) ? obs_q[k][i] : -1;
            e = (i < exp_q[k].size()) ? exp_q[k][i] : -1;
            chk($sformatf("%s_cycle%0d", tag, i), o, e);
        end
        obs_q[k].delete();
        exp_q[k].delete();
    endtask

    task automatic check_all(input string tag);
        check_events({tag, "_en"},    K_EN);
        check_events({tag, "_clr"},   K_CLR);
        check_events({tag, "_press"}, K_PRESS);
        check_events({tag, "_rise"},  K_RISE);
        check_events({tag, "_fall"},  K_FALL);
    endtask

    logic [3:0] an_a3  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [3:0] val_a3 [2] = '{4'h3, 4'hA};
    logic [3:0] an_z   [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};

    initial begin
        int k0, p0, r0, s0, b0, t0;

        bus.btn_start_stop = 1'b0;
        bus.btn_clear      = 1'b0;
        bus.count_in       = 16'h0000;
        rst = 1'b1;
        go_to(2);
        chk("rst_running",   bus.running,   1'b0);
        chk("rst_count_en",  bus.count_en,  1'b0);
        chk("rst_count_clr", bus.count_clr, 1'b0);
        chk("rst_an_n",      bus.an_n,      4'b1110);
        chk("rst_digit_val", bus.digit_val, 4'h0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) obs_q[k].delete();

        // Start from IDLE with a clean 10-cycle hold.
        k0 = cyc;
        bus.btn_start_stop = 1'b1;
        exp_q[K_PRESS].push_back(k0 + 7);
        exp_q[K_RISE].push_back(k0 + 8);
        exp_q[K_EN].push_back(k0 + 13);
        exp_q[K_EN].push_back(k0 + 18);
        exp_q[K_EN].push_back(k0 + 23);
        go_to(k0 + 10);
        bus.btn_start_stop = 1'b0;
        go_to(k0 + 25);
        check_all("start");
        chk("start_running", bus.running, 1'b1);

        // Pause, idle a while, then resume.
        p0 = cyc;
        bus.btn_start_stop = 1'b1;
        exp_q[K_EN].push_back(p0 + 3);
        exp_q[K_PRESS].push_back(p0 + 7);
        exp_q[K_FALL].push_back(p0 + 8);
        go_to(p0 + 8);
        bus.btn_start_stop = 1'b0;
        go_to(p0 + 15);
        chk("pause_running", bus.running, 1'b0);
        r0 = p0 + 20;
        go_to(r0);
        bus.btn_start_stop = 1'b1;
        exp_q[K_PRESS].push_back(r0 + 7);
        exp_q[K_RISE].push_back(r0 + 8);
        exp_q[K_EN].push_back(r0 + 13);
        exp_q[K_EN].push_back(r0 + 18);
        go_to(r0 + 8);
        bus.btn_start_stop = 1'b0;
        go_to(r0 + 20);
        check_all("pause_resume");

        // Clear and start/stop pressed together while running.
        s0 = cyc;
        bus.btn_start_stop = 1'b1;
        bus.btn_clear      = 1'b1;
        exp_q[K_EN].push_back(s0 + 3);
        exp_q[K_PRESS].push_back(s0 + 7);
        exp_q[K_CLR].push_back(s0 + 8);
        exp_q[K_FALL].push_back(s0 + 8);
        go_to(s0 + 8);
        bus.btn_start_stop = 1'b0;
        bus.btn_clear      = 1'b0;
        chk("simul_count_clr", bus.count_clr, 1'b1);
        chk("simul_count_en",  bus.count_en,  1'b0);
        chk("simul_running",   bus.running,   1'b0);
        go_to(s0 + 20);
        check_all("simul");
        chk("simul_idle_running", bus.running, 1'b0);

        // Bouncing input must never be accepted.
        b0 = cyc;
        bus.btn_start_stop = 1'b1;
        go_to(b0 + 1);
        bus.btn_start_stop = 1'b0;
        go_to(b0 + 2);
        bus.btn_start_stop = 1'b1;
        go_to(b0 + 3);
        bus.btn_start_stop = 1'b0;
        go_to(b0 + 20);
        check_all("bounce");
        chk("bounce_running", bus.running, 1'b0);

        // Scan with leading-zero blanking.
        bus.count_in = 16'h00A3;
        go_to(cyc + 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("scan_a3_an_d%0d", m_idx), bus.an_n, an_a3[m_idx]);
            if (m_idx < 2)
                chk($sformatf("scan_a3_val_d%0d", m_idx), bus.digit_val, val_a3[m_idx]);
            go_to(cyc + 1);
        end
        bus.count_in = 16'h0000;
        go_to(cyc + 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("scan_zero_an_d%0d", m_idx), bus.an_n, an_z[m_idx]);
            if (m_idx == 0)
                chk("scan_zero_val_d0", bus.digit_val, 4'h0);
            go_to(cyc + 1);
        end

        // Reset while running.
        for (int k = 0; k < 5; k++) obs_q[k].delete();
        bus.count_in = 16'h1234;
        t0 = cyc;
        bus.btn_start_stop = 1'b1;
        go_to(t0 + 8);
        bus.btn_start_stop = 1'b0;
        go_to(t0 + 11);
        chk("rstrun_pre_running", bus.running, 1'b1);
        rst = 1'b1;
        go_to(t0 + 12);
        chk("rstrun_running",   bus.running,   1'b0);
        chk("rstrun_an_n",      bus.an_n,      4'b1110);
        chk("rstrun_count_clr", bus.count_clr, 1'b0);
        chk("rstrun_count_en",  bus.count_en,  1'b0);
        rst = 1'b0;
        go_to(t0 + 20);
        chk("rstrun_after_running", bus.running, 1'b0);
        chk("rstrun_no_clr", obs_q[K_CLR].size(), 0);
        chk("rstrun_no_en",  obs_q[K_EN].size(),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
- Controller that sequences the 8/16-bit up-counter datapath and time-multiplexes its value onto a 4-digit 7-segment display.
- Debounces the start/stop and clear buttons and runs an IDLE/RUN/PAUSE state machine that issues count-enable ticks and clear pulses to the counter.
- Scans the counter value one hex nibble at a time into the existing seg7 decoder, with active-low digit anodes.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before a button level change is accepted (>=2).
- TICK_DIV, 1000, clk cycles between count_en pulses while running (>=2).
- SCAN_DIV, 1024, clk cycles each digit stays selected (>=2).
- LZ_BLANK, 1, 1 = blank leading-zero digits; 0 = always show all 4 digits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_start_stop  in  1  raw, asynchronous start/stop pushbutton (1 = pressed).
- btn_clear  in  1  raw, asynchronous clear pushbutton (1 = pressed).
- count_in  in  16  current counter value, 4 hex digits; digit 0 = [3:0].
- count_en  out  1  one-cycle pulse: counter increments by 1.
- count_clr  out  1  one-cycle pulse: counter loads 0.
- running  out  1  1 while the FSM is in RUN.
- digit_val  out  4  nibble for the currently selected digit, to seg7.counter.
- an_n  out  4  active-low one-hot digit anode select.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values (the cycle after rst is sampled high): state = IDLE, count_en = 0, count_clr = 0, running = 0, digit_idx = 0, an_n = 4'b1110, all prescalers = 0, debounced levels = 0.
- All outputs are registered.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounced level toggles only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
  - A press event is a one-cycle pulse on the debounced rising edge only; release produces no event.
  - Latency from a clean raw edge to the press pulse is DEBOUNCE_CYCLES + 3 cycles.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop press -> RUN.
  - RUN + start_stop press -> PAUSE.
  - PAUSE + start_stop press -> RUN.
  - Any state + clear press -> IDLE, with count_clr = 1 for exactly one cycle.
  - Clear and start_stop presses in the same cycle: clear wins; the start_stop press is dropped.
  - rst mid-operation returns to IDLE immediately and does not pulse count_clr.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - Zeroed on every entry to RUN; holds its value in PAUSE/IDLE, but is zeroed again on re-entry.
  - count_en = 1 in the cycle the prescaler wraps, so the first pulse comes TICK_DIV cycles after running rises.
  - count_en never pulses outside RUN and never in the same cycle as count_clr.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 continuously in all states.
  - On wrap, digit_idx increments mod 4 (wrap 3 -> 0).
  - digit_val = count_in[4*digit_idx +: 4], registered, so it follows count_in with 1-cycle latency.
  - an_n = ~(4'b0001 << digit_idx).
- Leading-zero blanking (LZ_BLANK = 1):
  - For digit_idx > 0, if that nibble and all more-significant nibbles are 0, an_n = 4'b1111.
  - Digit 0 is never blanked, so count_in = 0 shows a single "0".

Decomposition:
- Shared package counter_pkg:
  - state enum constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2.
  - NUM_DIGITS = 4.
  - Anode idle pattern AN_OFF = 4'b1111.
- One sub-module, btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst, raw, level, press). Instantiate it twice.
- The seg7 decoder stays outside this block and is fed by digit_val.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=5, SCAN_DIV=4, LZ_BLANK=1):
- Debounce and tick timing: hold btn_start_stop high for 10 cycles.
  - Exactly one press pulse, 7 cycles after the raw edge.
  - running rises 1 cycle later.
  - count_en pulses at 5, 10, 15... cycles after running rises.
- Bounce rejection: toggle btn_start_stop 1,0,1,0 on alternating cycles, then hold 0.
  - No press pulse; state stays IDLE; count_en stays 0.
- Pause/resume: press, press, press.
  - Sequence IDLE -> RUN -> PAUSE -> RUN.
  - No count_en while in PAUSE.
  - First count_en after resume is 5 cycles after running re-rises.
- Simultaneous events: press clear and start_stop on the same raw cycle while in RUN.
  - Single count_clr pulse; state = IDLE; running = 0; no count_en that cycle.
- Scan/blanking with count_in = 16'h00A3: over 16 cycles, sample an_n once per digit (4 cycles each).
  - digit 0: an_n = 1110, digit_val = 3.
  - digit 1: an_n = 1101, digit_val = A.
  - digit 2: an_n = 1111.
  - digit 3: an_n = 1111.
  - With count_in = 0: digit 0 shows 0 and digits 1-3 are blanked.
- Reset mid-run: assert rst for 1 cycle in RUN with count_in = 16'h1234.
  - Next cycle: IDLE, running = 0, an_n = 1110, count_clr = 0, count_en = 0.
